zzadd_arb4: RTL and testbench
=============================

ZZADD_ARB4 -- requirements
Module: zzadd_arb4

Interface
REQ-001 SHALL have parameter PTR_RST, default 0, giving the round-robin pointer value after reset (0..3).
REQ-002 SHALL have port rclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port arst_l, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_vld, input, 4 bits: per-requester operation request.
REQ-005 SHALL have port req_op64, input, 4 bits: per requester, 1 selects a 64-bit add and 0 selects a 32-bit add.
REQ-006 SHALL have port req_a, input, 256 bits: operand A, requester i on bits [64i+63:64i].
REQ-007 SHALL have port req_b, input, 256 bits: operand B, same packing as req_a.
REQ-008 SHALL have port req_cin, input, 4 bits: per-requester carry-in.
REQ-009 SHALL have port req_rdy, output, 4 bits: one-hot grant; operands are captured in the cycle it is high.
REQ-010 SHALL have port res_vld, output, 1 bit: result valid.
REQ-011 SHALL have port res_rdy, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port res_id, output, 2 bits: index of the requester that owns the result.
REQ-013 SHALL have port res_data, output, 64 bits: sum.
REQ-014 SHALL have ports res_cout32 and res_cout64, outputs, 1 bit each: carry out of bit 31 and carry out of bit 63.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement a single shared 32-bit adder (a + b + c) and SHALL NOT use any wider adder.
REQ-017 SHALL implement a state machine with states IDLE, LO, HI and HOLD.
REQ-018 Grant SHALL be possible in IDLE, or in HOLD in the same cycle that res_rdy=1; the winner SHALL be the first requester with req_vld=1, searching ptr, ptr+1, ... mod 4.
REQ-019 On a grant, req_rdy SHALL be one-hot for the winner and all zeros otherwise.
REQ-020 On a grant, the block SHALL capture a, b, cin, op64 and the id, set ptr to winner+1 mod 4, and go to LO.
REQ-021 LO SHALL add a[31:0] + b[31:0] + cin and store the low sum and carry c32.
REQ-022 From LO, a 32-bit op SHALL go to HOLD; a 64-bit op SHALL go to HI.
REQ-023 HI SHALL add a[63:32] + b[63:32] + c32 and then go to HOLD.
REQ-024 For a 32-bit op: res_data[63:32]=0 and res_cout64=res_cout32=c32.
REQ-025 Latency from grant edge to res_vld SHALL be 2 cycles for a 32-bit op and 3 cycles for a 64-bit op.
REQ-026 In HOLD, res_vld=1 and res_id, res_data and the carries SHALL be stable until res_rdy=1.
REQ-027 On HOLD with res_rdy=1: a pending request SHALL be granted (go to LO), otherwise the state SHALL go to IDLE.
REQ-028 res_vld SHALL be 0 in IDLE, LO and HI; res_rdy SHALL be ignored outside HOLD.
REQ-029 No request in IDLE SHALL keep the state and ptr unchanged.
REQ-030 Dropping req_vld before grant SHALL have no effect; requests SHALL NOT be queued.
REQ-031 req_* inputs SHALL be ignored in LO and HI, and in HOLD while res_rdy=0.
REQ-032 Sums SHALL wrap modulo 2^32 per half; overflow SHALL be reported only through the carries.

Reset
REQ-033 arst_l low SHALL immediately force: state=IDLE, ptr=PTR_RST, req_rdy=0, res_vld=0, res_id=0, res_data=0, res_cout32=0, res_cout64=0, busy=0.
REQ-034 Reset asserted mid-operation (LO, HI or HOLD) SHALL abandon the operation without producing a result.
REQ-035 Deassertion of arst_l SHALL take effect at the first rclk edge after release; the first grant is possible in that cycle.

Configuration
REQ-036 With ZZADD_ARB4_PAR_EN defined, the block SHALL add output port res_par (1 bit), equal to the XOR of res_data[63:0] and registered with res_data; res_par SHALL be 0 at reset.
REQ-037 Without ZZADD_ARB4_PAR_EN, port res_par SHALL be absent and there SHALL be no parity logic.

Verification
REQ-038 Requester 2 requests 32-bit, a=0xFFFFFFFF, b=1, cin=0 -> req_rdy=0100; 2 cycles later res_vld=1, res_id=2, res_data=0, res_cout32=1, res_cout64=1.
REQ-039 Requester 0 requests 64-bit, a=0x00000000FFFFFFFF, b=1, cin=0 -> 3 cycles later res_data=0x0000000100000000, res_cout32=1, res_cout64=0.
REQ-040 All four requesters request continuously with res_rdy=1 and PTR_RST=0 -> grants in order 0, 1, 2, 3, 0; back-to-back grant occurs in the HOLD cycle.
REQ-041 64-bit request, a=b=0xFFFFFFFFFFFFFFFF, cin=1 while res_rdy=0 for 5 cycles -> res_data=0xFFFFFFFFFFFFFFFF held stable, res_cout64=1; no grant until res_rdy=1.
REQ-042 arst_l pulsed low during HI -> all outputs go to 0 immediately, no res_vld, and the next grant starts from PTR_RST.
REQ-043 With ZZADD_ARB4_PAR_EN: a=0x3, b=0, cin=0, 32-bit op -> res_data=0x3, res_par=0.

Source files
------------

// File: rtl/zzadd_arb4.sv
// zzadd_arb4: 4-way round-robin arbiter sharing one 32-bit adder; 64-bit adds take a LO then HI pass.
// Optional res_par output (XOR of res_data) when ZZADD_ARB4_PAR_EN is defined.
module zzadd_arb4 #(
  parameter int PTR_RST = 0
) (
  input  logic         rclk,
  input  logic         arst_l,
  input  logic [3:0]   req_vld,
  input  logic [3:0]   req_op64,
  input  logic [255:0] req_a,
  input  logic [255:0] req_b,
  input  logic [3:0]   req_cin,
  output logic [3:0]   req_rdy,
  output logic         res_vld,
  input  logic         res_rdy,
  output logic [1:0]   res_id,
  output logic [63:0]  res_data,
  output logic         res_cout32,
  output logic         res_cout64,
`ifdef ZZADD_ARB4_PAR_EN
  output logic         res_par,
`endif
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, LO, HI, HOLD} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, id_q, id_d, win;
  logic [63:0] a_q, a_d, b_q, b_d;
  logic [31:0] lo_q, lo_d, hi_q, hi_d;
  logic cin_q, cin_d, op64_q, op64_d, c32_q, c32_d, c64_q, c64_d;
  logic found, gnt, lo;
  logic [32:0] sum;
  always_comb begin
    win = ptr_q;
    found = 1'b0;
    for (int i = 3; i >= 0; i--)
      if (req_vld[ptr_q + 2'(i)]) begin
        win = ptr_q + 2'(i);
        found = 1'b1;
      end
  end
  assign gnt = arst_l & found & ((state_q == IDLE) | ((state_q == HOLD) & res_rdy));
  assign req_rdy = gnt ? 4'b1 << win : 4'b0;
  assign lo = state_q == LO;
  // the only adder: low halves with cin in LO, high halves with the stored carry in HI
  assign sum = {1'b0, lo ? a_q[31:0] : a_q[63:32]} + {1'b0, lo ? b_q[31:0] : b_q[63:32]}
             + {32'b0, lo ? cin_q : c32_q};
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    cin_d = cin_q;
    op64_d = op64_q;
    lo_d = lo_q;
    hi_d = hi_q;
    c32_d = c32_q;
    c64_d = c64_q;
    if (gnt) begin
      state_d = LO;
      ptr_d = win + 2'd1;
      id_d = win;
      a_d = req_a[64*win +: 64];
      b_d = req_b[64*win +: 64];
      cin_d = req_cin[win];
      op64_d = req_op64[win];
      hi_d = '0;
      c64_d = 1'b0;
    end else if (state_q == LO) begin
      state_d = op64_q ? HI : HOLD;
      lo_d = sum[31:0];
      c32_d = sum[32];
      c64_d = sum[32];
    end else if (state_q == HI) begin
      state_d = HOLD;
      hi_d = sum[31:0];
      c64_d = sum[32];
    end else if (state_q == HOLD && res_rdy)
      state_d = IDLE;
  end
`ifdef ZZADD_ARB4_PAR_EN
  logic par_q, par_d;
  assign par_d = ^{hi_d, lo_d};
  assign res_par = par_q;
`endif
  always_ff @(posedge rclk or negedge arst_l)
    if (!arst_l) begin
      state_q <= IDLE;
      ptr_q <= 2'(PTR_RST);
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      op64_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      c32_q <= 1'b0;
      c64_q <= 1'b0;
`ifdef ZZADD_ARB4_PAR_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      cin_q <= cin_d;
      op64_q <= op64_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      c32_q <= c32_d;
      c64_q <= c64_d;
`ifdef ZZADD_ARB4_PAR_EN
      par_q <= par_d;
`endif
    end
  assign res_vld = state_q == HOLD;
  assign busy = state_q != IDLE;
  assign res_id = id_q;
  assign res_data = {hi_q, lo_q};
  assign res_cout32 = c32_q;
  assign res_cout64 = c64_q;
endmodule

// File: tb/tb_zzadd_arb4.sv
// tb_zzadd_arb4: directed vector table, reset/round-robin sequences, then random traffic vs a reference model.
module tb_zzadd_arb4;
  logic rclk = 1'b0, arst_l = 1'b1;
  logic [3:0] req_vld = '0, req_op64 = '0, req_cin = '0, req_rdy;
  logic [255:0] req_a = '0, req_b = '0;
  logic res_vld, res_rdy = 1'b0, res_cout32, res_cout64, busy;
  logic [1:0] res_id;
  logic [63:0] res_data;
`ifdef ZZADD_ARB4_PAR_EN
  logic res_par;
`endif
  zzadd_arb4 dut (
    .rclk(rclk), .arst_l(arst_l), .req_vld(req_vld), .req_op64(req_op64),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_rdy(req_rdy),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_id(res_id), .res_data(res_data),
    .res_cout32(res_cout32), .res_cout64(res_cout64),
`ifdef ZZADD_ARB4_PAR_EN
    .res_par(res_par),
`endif
    .busy(busy)
  );
  always #5 rclk = ~rclk;
  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask
  function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return 2'((p + k) % 4);
    return p;
  endfunction
  function automatic int idx1h(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return -1;
  endfunction
  // returns {cout64, cout32, data}
  function automatic logic [65:0] ref_add(input logic op64, input logic [63:0] a, input logic [63:0] b, input logic cin);
    logic [32:0] l;
    logic [64:0] f;
    l = {1'b0, a[31:0]} + {1'b0, b[31:0]} + 33'(cin);
    f = {1'b0, a} + {1'b0, b} + 65'(cin);
    return op64 ? {f[64], l[32], f[63:0]} : {l[32], l[32], 32'b0, l[31:0]};
  endfunction
  function automatic logic [255:0] r256();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, req_rdy, 0);
    chk({tag, "_vld"}, res_vld, 0);
    chk({tag, "_id"}, res_id, 0);
    chk({tag, "_data"}, res_data, 0);
    chk({tag, "_cout"}, {res_cout64, res_cout32}, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef ZZADD_ARB4_PAR_EN
    chk({tag, "_par"}, res_par, 0);
`endif
  endtask
  typedef struct {
    logic [1:0] id;
    logic op64;
    logic [63:0] a, b;
    logic cin;
    int hold;
    logic [63:0] d;
    logic c32, c64;
  } vec_t;
  vec_t vt[6];
  logic [1:0] mptr, ew, eid;
  logic [3:0] erdy;
  logic [65:0] r;
  logic [63:0] ha;
  logic holding, gok;
  int cnt, n, ng;
  int gid[5];
  logic gb2b[5];
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0] = '{2'd2, 1'b0, 64'hFFFFFFFF, 64'h1, 1'b0, 0, 64'h0, 1'b1, 1'b1};
    vt[1] = '{2'd0, 1'b1, 64'h00000000FFFFFFFF, 64'h1, 1'b0, 0, 64'h0000000100000000, 1'b1, 1'b0};
    vt[2] = '{2'd1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 5, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1};
    vt[3] = '{2'd3, 1'b0, 64'h3, 64'h0, 1'b0, 0, 64'h3, 1'b0, 1'b0};
    vt[4] = '{2'd0, 1'b0, 64'hDEADBEEF12345678, 64'h1111111111111111, 1'b1, 2, 64'h000000002345678A, 1'b0, 1'b0};
    vt[5] = '{2'd1, 1'b1, 64'h7FFFFFFF80000000, 64'h0000000080000000, 1'b0, 0, 64'h8000000000000000, 1'b1, 1'b0};
    arst_l = 1'b0;
    req_vld = 4'hF;
    #12;
    chk_reset("rst");
    req_vld = 4'h0;
    arst_l = 1'b1;
    tick();
    foreach (vt[i]) begin
      req_a[64*vt[i].id +: 64] = vt[i].a;
      req_b[64*vt[i].id +: 64] = vt[i].b;
      req_cin[vt[i].id] = vt[i].cin;
      req_op64[vt[i].id] = vt[i].op64;
      req_vld = 4'b1 << vt[i].id;
      res_rdy = 1'b0;
      #1;
      chk("grant", req_rdy, 4'b1 << vt[i].id);
      tick();
      req_vld = 4'h0;
      req_a = r256();
      req_b = r256();
      n = 1;
      while (!res_vld && n < 8) begin
        tick();
        n++;
      end
      chk("latency", n, vt[i].op64 ? 3 : 2);
      chk("id", res_id, vt[i].id);
      chk("data", res_data, vt[i].d);
      chk("cout32", res_cout32, vt[i].c32);
      chk("cout64", res_cout64, vt[i].c64);
`ifdef ZZADD_ARB4_PAR_EN
      chk("par", res_par, ^vt[i].d);
`endif
      for (int h = 0; h < vt[i].hold; h++) begin
        req_vld = 4'hF;
        tick();
        chk("hold_rdy", req_rdy, 0);
        chk("hold_vld", res_vld, 1);
        chk("hold_data", res_data, vt[i].d);
        chk("hold_cout64", res_cout64, vt[i].c64);
      end
      req_vld = 4'h0;
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;
      chk("release", {busy, res_vld}, 0);
    end
    req_op64[2] = 1'b1;
    req_vld = 4'b0100;
    tick();
    req_vld = 4'h0;
    tick();
    chk("hi_busy", busy, 1);
    req_vld = 4'hF;
    arst_l = 1'b0;
    #1;
    chk_reset("midrst");
    #2;
    arst_l = 1'b1;
    req_vld = 4'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_idle", {busy, res_vld}, 0);
    end
    req_vld = 4'hF;
    #1;
    chk("post_rst_ptr", req_rdy, 4'b0001);
    req_op64 = 4'h0;
    res_rdy = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      #1;
      if (req_rdy != 0) begin
        gid[ng] = idx1h(req_rdy);
        gb2b[ng] = res_vld;
        ng++;
      end
      @(posedge rclk);
    end
    #1;
    req_vld = 4'h0;
    chk("rr_count", ng, 5);
    for (int k = 0; k < ng; k++) chk("rr_order", gid[k], k % 4);
    for (int k = 0; k < ng; k++) chk("rr_b2b", gb2b[k], k != 0);
    tick();
    tick();
    arst_l = 1'b0;
    #2;
    arst_l = 1'b1;
    tick();
    mptr = 2'(0);
    holding = 1'b0;
    cnt = 0;
    eid = '0;
    r = '0;
    for (int it = 0; it < 1500; it++) begin
      req_vld = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom());
      req_op64 = 4'($urandom());
      req_cin = 4'($urandom());
      req_a = r256();
      req_b = r256();
      if ($urandom_range(0, 7) == 0) req_a[63:0] = 64'hFFFFFFFFFFFFFFFF;
      res_rdy = 1'($urandom_range(0, 1));
      #1;
      gok = (!holding && cnt == 0) || (holding && res_rdy);
      ew = pick(req_vld, mptr);
      erdy = (gok && req_vld != 0) ? 4'b1 << ew : 4'h0;
      chk("rnd_rdy", req_rdy, erdy);
      chk("rnd_vld", res_vld, holding);
      chk("rnd_busy", busy, holding || cnt != 0);
      if (holding) begin
        chk("rnd_id", res_id, eid);
        chk("rnd_data", res_data, r[63:0]);
        chk("rnd_cout", {res_cout64, res_cout32}, r[65:64]);
`ifdef ZZADD_ARB4_PAR_EN
        chk("rnd_par", res_par, ^r[63:0]);
`endif
      end
      if (gok && req_vld != 0) begin
        ha = req_a[64*ew +: 64];
        r = ref_add(req_op64[ew], ha, req_b[64*ew +: 64], req_cin[ew]);
        eid = ew;
        mptr = ew + 2'd1;
        holding = 1'b0;
        cnt = req_op64[ew] ? 2 : 1;
      end else if (gok && holding)
        holding = 1'b0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) holding = 1'b1;
      end
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
